mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 8, giving the word-address width; memory depth is 2^ADDR_WIDTH words.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 16, giving the word width.
REQ-003 The block SHALL take parameter LATENCY, default 2, giving cycles from request accept to response valid; legal range is 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit, meaning the core presents a request.
REQ-007 The block SHALL have port req_ready, output, 1 bit, meaning the responder accepts a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 is write, 0 is read.
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH bits, the word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_WIDTH bits, the write data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, meaning the response is present.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits, the read data.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit, meaning the core accepts the response.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-016 In IDLE the block SHALL drive req_ready=1; in WAIT and RESP it SHALL drive req_ready=0.
REQ-017 When req_valid=1 and req_ready=1 at a rising edge (accept edge), the block SHALL latch req_we, req_addr and req_wdata, load the counter with LATENCY-1, and enter WAIT.
REQ-018 Request inputs SHALL be ignored in all other cycles; a request is never queued.
REQ-019 In WAIT with counter>0, the block SHALL decrement the counter at each edge.
REQ-020 In WAIT with counter==0, the block SHALL perform the latched access at that edge and enter RESP.
REQ-021 The access in REQ-020 SHALL be: a read loads rsp_rdata from mem[addr]; a write stores wdata into mem[addr] and loads rsp_rdata with 0.
REQ-022 rsp_valid SHALL be 1 exactly in RESP, first asserting LATENCY cycles after the accept edge.
REQ-023 In RESP, rsp_rdata SHALL hold stable until the handshake.
REQ-024 In RESP with rsp_ready=1 at an edge, the block SHALL return to IDLE, so the next accept is possible one cycle later.
REQ-025 In RESP with rsp_ready=0, the block SHALL remain in RESP indefinitely (backpressure).
REQ-026 rsp_ready SHALL be ignored outside RESP.
REQ-027 Addresses SHALL be fully decoded; no out-of-range case exists.
REQ-028 A read of a word written earlier SHALL return the last committed write data.
REQ-029 Memory contents SHALL NOT be reset; unwritten words read as undefined.

Reset
REQ-030 On reset assertion, the block SHALL immediately set state to IDLE, counter to 0, rsp_valid to 0, rsp_rdata to 0 and busy to 0, and req_ready SHALL be 1 once reset deasserts.
REQ-031 If reset asserts while in WAIT, the pending access SHALL be abandoned; a pending write SHALL NOT be committed.
REQ-032 If reset asserts while in RESP, the response SHALL be dropped.
REQ-033 Reset SHALL NOT alter memory contents; a write committed before reset SHALL be readable after reset.

Verification (LATENCY=2, ADDR_WIDTH=8, DATA_WIDTH=16)
REQ-034 The bench SHALL check write then read: write 0xBEEF to addr 0x10 and handshake, then read 0x10 -> rsp_valid 2 cycles after each accept; write rsp_rdata=0x0000; read rsp_rdata=0xBEEF.
REQ-035 The bench SHALL check backpressure: read 0x10 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0xBEEF stable, req_ready=0, busy=1 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-036 The bench SHALL check request blocking: hold req_valid=1 with write 0x1234 to addr 0x20 during WAIT/RESP of a prior read -> no second accept until IDLE; after completion mem[0x20]=0x1234 written once.
REQ-037 The bench SHALL check reset in WAIT: accept write 0x5555 to addr 0x30 (mem[0x30] previously 0xAAAA), assert reset one cycle later -> rsp_valid=0 and busy=0 immediately; a later read of 0x30 returns 0xAAAA.
REQ-038 The bench SHALL check the wrap boundary: write 0x00FF to addr 0xFF and 0xFF00 to addr 0x00 -> reads return 0x00FF and 0xFF00 respectively, with no aliasing.
REQ-039 The bench SHALL check the latency parameter: with LATENCY=1, a read is accepted at edge N -> rsp_valid=1 after edge N+1; with LATENCY=4 -> after edge N+4.

Source files
------------

// File: rtl/mem_responder.sv
// Word memory behind a request/response handshake. It serves one request at a
// time, and the response appears a fixed LATENCY cycles after the request is accepted.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_ready,
  output logic                  busy
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  accept;
  logic                  do_access;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_ready && req_valid;
  assign do_access = (state == WAIT) && (cnt == 4'd0);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state defaults to the current state before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt       <= CNT_LOAD;
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Writes answer with zero; a read captures the addressed word.
      if (do_access) rsp_rdata <= lat_we ? '0 : mem[lat_addr];
    end
  end

  // NOTE: the storage array has no reset. Contents survive reset. Reset forces
  // IDLE asynchronously, so an access still pending in WAIT is never committed.
  always_ff @(posedge clk) begin
    if (do_access && lat_we) mem[lat_addr] <= lat_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder. A LATENCY=2 instance carries
// the functional checks, and LATENCY=1 and LATENCY=4 instances time the response.
module tb_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;

  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_rdata;
  logic          req_ready1, rsp_valid1, busy1;
  logic [DW-1:0] rsp_rdata1;
  logic          req_ready4, rsp_valid4, busy4;
  logic [DW-1:0] rsp_rdata4;

  int n_tests = 0;
  int n_fail = 0;
  int accept_cnt = 0;

  // Reference memory: the last committed write per word, plus a written flag.
  logic [DW-1:0] model_mem [256];
  bit            model_vld [256];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready), .busy(busy)
  );

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_ready(rsp_ready), .busy(busy1)
  );

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_ready(rsp_ready), .busy(busy4)
  );

  // Counts the accept edges of the LATENCY=2 instance.
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) accept_cnt <= accept_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the LATENCY=2 instance. The task holds off
  // rsp_ready for 'stall' cycles once the response is visible.
  task automatic transact(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int stall, output logic [DW-1:0] rdata, output int lat);
    int k;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check("busy_in_wait", 32'(busy), 32'd1);
      check("req_ready_in_wait", 32'(req_ready), 32'd0);
      step();
      lat++;
    end
    rdata = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      step();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata_stable", 32'(rsp_rdata), 32'(rdata));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("idle_after_handshake_busy", 32'(busy), 32'd0);
    check("idle_after_handshake_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int stall);
    logic [DW-1:0] rd;
    int lat;
    transact(1'b1, addr, data, stall, rd, lat);
    check("write_latency", 32'(lat), 32'd2);
    check("write_rsp_rdata", 32'(rd), 32'd0);
    model_mem[addr] = data;
    model_vld[addr] = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int stall);
    logic [DW-1:0] rd;
    int lat;
    transact(1'b0, addr, '0, stall, rd, lat);
    check("read_latency", 32'(lat), 32'd2);
    if (model_vld[addr]) check("read_rsp_rdata", 32'(rd), 32'(model_mem[addr]));
  endtask

  initial begin
    int a0, k, k1, k4;
    for (int i = 0; i < 256; i++) model_vld[i] = 1'b0;

    // Reset values, checked while reset is still held.
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    step(); step();
    reset = 1'b0;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Write followed by read.
    do_write(8'h10, 16'hBEEF, 0);
    do_read(8'h10, 0);

    // Backpressure: the response must hold for five stalled cycles.
    do_read(8'h10, 5);

    // Request blocking: keep a write presented during a pending read.
    a0 = accept_cnt;
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    step();
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'h1234;
    k = 0;
    while (!rsp_valid && k < 20) begin
      check("blk_req_ready_wait", 32'(req_ready), 32'd0);
      step(); k++;
    end
    check("blk_read_latency", 32'(k), 32'd2);
    for (int s = 0; s < 2; s++) begin
      check("blk_req_ready_resp", 32'(req_ready), 32'd0);
      step();
    end
    check("blk_read_rdata", 32'(rsp_rdata), 32'hBEEF);
    check("blk_one_accept", 32'(accept_cnt - a0), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("blk_no_accept_yet", 32'(accept_cnt - a0), 32'd1);
    check("blk_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("blk_second_accept", 32'(accept_cnt - a0), 32'd2);
    k = 0;
    while (!rsp_valid && k < 20) begin step(); k++; end
    check("blk_write_latency", 32'(k), 32'd2);
    check("blk_write_rdata", 32'(rsp_rdata), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step(); step(); step();
    check("blk_written_once", 32'(accept_cnt - a0), 32'd2);
    check("blk_idle", 32'(busy), 32'd0);
    model_mem[8'h20] = 16'h1234;
    model_vld[8'h20] = 1'b1;
    do_read(8'h20, 0);

    // Reset while in WAIT: the pending write must be dropped.
    do_write(8'h30, 16'hAAAA, 0);
    req_we = 1'b1; req_addr = 8'h30; req_wdata = 16'h5555; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_rsp_rdata", 32'(rsp_rdata), 32'd0);
    step();
    reset = 1'b0;
    check("rst_wait_req_ready", 32'(req_ready), 32'd1);
    do_read(8'h30, 0);

    // Reset while in RESP: the response must be dropped.
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin step(); k++; end
    reset = 1'b1;
    #1;
    check("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    reset = 1'b0;
    check("rst_resp_busy", 32'(busy), 32'd0);

    // Address wrap boundary.
    do_write(8'hFF, 16'h00FF, 0);
    do_write(8'h00, 16'hFF00, 0);
    do_read(8'hFF, 0);
    do_read(8'h00, 0);

    // Random traffic, checked against the reference memory.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] ra;
      ra = {4'($urandom_range(0, 15)), 4'h7};
      if ($urandom_range(0, 1) == 1) do_write(ra, 16'($urandom), $urandom_range(0, 2));
      else                           do_read(ra, $urandom_range(0, 2));
    end

    // Latency parameter: drain every instance to IDLE, then issue one shared read.
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int s = 0; s < 8; s++) step();
    rsp_ready = 1'b0;
    check("lat_all_idle_1", 32'(req_ready1), 32'd1);
    check("lat_all_idle_4", 32'(req_ready4), 32'd1);
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    k1 = 0; k4 = 0; k = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (rsp_valid1 && k1 == 0) k1 = c;
      if (rsp_valid  && k  == 0) k  = c;
      if (rsp_valid4 && k4 == 0) k4 = c;
    end
    check("lat1_cycles", 32'(k1), 32'd1);
    check("lat2_cycles", 32'(k), 32'd2);
    check("lat4_cycles", 32'(k4), 32'd4);
    rsp_ready = 1'b1;
    step(); step();
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
